// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, credit widths
// and the per-line debounce state encoding.
package vm_pkg;

    // Coin code carried through the intake FIFO into the datapath adder select.
    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_2  = 2'b01,
        COIN_10 = 2'b10,
        COIN_20 = 2'b11
    } coin_code_t;

    // Per-line debounce states.
    typedef enum logic [1:0] {
        DEB_IDLE  = 2'b00,
        DEB_COUNT = 2'b01,
        DEB_HELD  = 2'b10
    } deb_state_t;

    localparam int COIN_VAL_1  = 1;
    localparam int COIN_VAL_2  = 2;
    localparam int COIN_VAL_10 = 10;
    localparam int COIN_VAL_20 = 20;

    // Credit register width in the datapath, and the width used for pending credit.
    localparam int CREDIT_W = 7;
    localparam int PEND_W   = 8;

    // Value in units of a coin code, sized for pending-credit arithmetic.
    function automatic logic [PEND_W-1:0] coin_val(input logic [1:0] code);
        case (code)
            2'b00:   return PEND_W'(COIN_VAL_1);
            2'b01:   return PEND_W'(COIN_VAL_2);
            2'b10:   return PEND_W'(COIN_VAL_10);
            default: return PEND_W'(COIN_VAL_20);
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin line: 2-flop synchroniser followed by a debounce FSM that emits a
// single qualify strobe once the synced line has been high DEB_CYC cycles.
module coin_debounce
    import vm_pkg::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic coin_raw,
    output logic qual
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             qual_nxt;

    // Synchronise the asynchronous coin line before anything looks at it.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: non-blocking assignments let sync_2 take the old sync_1, forming a real two-stage chain.
        if (!RST_N) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= coin_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce state, run-length counter and registered qualify strobe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= DEB_IDLE;
            cnt   <= '0;
            qual  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            qual  <= qual_nxt;
        end
    end

    // Count consecutive synced-high cycles; strobe once on entry to HELD.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        state_nxt = state;
        cnt_nxt   = cnt;
        qual_nxt  = 1'b0;
        unique case (state)
            DEB_IDLE: begin
                if (sync_2) begin
                    if (DEB_CYC <= 1) begin
                        state_nxt = DEB_HELD;
                        qual_nxt  = 1'b1;
                    end else begin
                        state_nxt = DEB_COUNT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DEB_COUNT: begin
                if (!sync_2) begin
                    state_nxt = DEB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DEB_HELD;
                    cnt_nxt   = '0;
                    qual_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DEB_HELD: begin
                if (!sync_2) state_nxt = DEB_IDLE;
            end
            default: begin
                state_nxt = DEB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_intake.sv
// Coin intake: four debounced coin lines, jam detection, and a small FIFO of
// coin codes handed to the credit controller with a valid/ready handshake.
// Optional feature macro COIN_REFUND_EN: refuse coins that would push pending
// credit over CREDIT_MAX and pulse REFUND instead of queueing them.
module coin_intake
    import vm_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEB_CYC    = 4,
    parameter int CREDIT_MAX = 20
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [3:0]          COIN,
    input  logic [CREDIT_W-1:0] CREDIT,
    input  logic                ADD_READY,
    output logic                ADD_VALID,
    output logic [1:0]          ADD_SEL,
    output logic                FULL,
    output logic                DROP,
    output logic                JAM,
    output logic                REFUND,
    output logic [1:0]          REFUND_SEL
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [3:0]       qual;
    logic [2:0]       qual_cnt;
    coin_code_t       qual_code;
    logic             cand_vld;
    coin_code_t       cand_code;
    logic             jam_q;
    logic             drop_q;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [1:0]       head_code;
    logic             fifo_full;
    logic             fifo_valid;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             drop_now;
    logic             refund_now;

    for (genvar g = 0; g < 4; g++) begin : g_line
        coin_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .coin_raw (COIN[g]),
            .qual     (qual[g])
        );
    end

    // Count simultaneous qualify strobes and encode the (single) strobing line.
    always_comb begin
        qual_cnt  = 3'd0;
        qual_code = COIN_1;
        for (int i = 0; i < 4; i++) begin
            if (qual[i]) begin
                qual_cnt  = qual_cnt + 3'd1;
                qual_code = coin_code_t'(i[1:0]);
            end
        end
    end

    // Candidate stage: a lone strobe becomes a push candidate, several become a jam.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand_vld  <= 1'b0;
            cand_code <= COIN_1;
            jam_q     <= 1'b0;
        end else begin
            cand_vld  <= (qual_cnt == 3'd1);
            cand_code <= qual_code;
            jam_q     <= (qual_cnt > 3'd1);
        end
    end

    assign fifo_full  = (occ == OCC_FULL);
    assign fifo_valid = (occ != '0);
    assign head_code  = mem[rd_ptr];
    assign pop        = fifo_valid && ADD_READY;
    assign push_req   = cand_vld && !refund_now;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = push_req && (!fifo_full || pop);
    assign drop_now   = push_req && !push;

`ifdef COIN_REFUND_EN
    logic [PEND_W-1:0] queued_sum;
    logic [PEND_W-1:0] pending;
    logic [PEND_W:0]   with_coin;
    logic [PEND_W-1:0] push_val;
    logic [PEND_W-1:0] pop_val;
    logic              refund_q;
    logic [1:0]        refund_sel_q;

    // Pending credit is the datapath credit plus everything still queued.
    assign pending    = PEND_W'(CREDIT) + queued_sum;
    assign with_coin  = {1'b0, pending} + {1'b0, coin_val(cand_code)};
    assign refund_now = cand_vld && (with_coin > (PEND_W + 1)'(CREDIT_MAX));
    assign push_val   = push ? coin_val(cand_code) : '0;
    assign pop_val    = pop ? coin_val(head_code) : '0;

    // Running sum of queued coin values, tracking every push and pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) queued_sum <= '0;
        else        queued_sum <= queued_sum + push_val - pop_val;
    end

    // Refund pulse carrying the rejected coin's code.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refund_q     <= 1'b0;
            refund_sel_q <= 2'b00;
        end else begin
            refund_q     <= refund_now;
            refund_sel_q <= refund_now ? cand_code : 2'b00;
        end
    end

    assign REFUND     = refund_q;
    assign REFUND_SEL = refund_sel_q;
`else
    // No ceiling check in this build; over-limit credit is the datapath's concern.
    logic unused_credit;
    assign unused_credit = ^{CREDIT, 1'(CREDIT_MAX)};
    assign refund_now    = 1'b0;
    assign REFUND        = 1'b0;
    assign REFUND_SEL    = 2'b00;
`endif

    // Coin storage.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array is deliberately not reset; ADD_SEL is gated by occupancy so stale entries never reach the port.
        if (push) mem[wr_ptr] <= cand_code;
    end

    // Pointers wrap naturally modulo DEPTH; occupancy follows push/pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Drop pulse for a coin that found the FIFO full with no pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) drop_q <= 1'b0;
        else        drop_q <= drop_now;
    end

    assign ADD_VALID = fifo_valid;
    assign ADD_SEL   = fifo_valid ? head_code : 2'b00;
    assign FULL      = fifo_full;
    assign DROP      = drop_q;
    assign JAM       = jam_q;

endmodule

// File: tb/tb_coin_intake.sv
// Self-checking bench for coin_intake: reset state, a table of single-event
// vectors, hand-written multi-cycle sequences and a randomized scoreboard run.
module tb_coin_intake;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] coin = 4'b0000;
    logic [6:0] credit = 7'd0;
    logic       add_ready = 1'b1;
    logic       add_valid;
    logic [1:0] add_sel;
    logic       full;
    logic       drop;
    logic       jam;
    logic       refund;
    logic [1:0] refund_sel;

    coin_intake #(
        .DEPTH      (4),
        .DEB_CYC    (DEB),
        .CREDIT_MAX (20)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .COIN       (coin),
        .CREDIT     (credit),
        .ADD_READY  (add_ready),
        .ADD_VALID  (add_valid),
        .ADD_SEL    (add_sel),
        .FULL       (full),
        .DROP       (drop),
        .JAM        (jam),
        .REFUND     (refund),
        .REFUND_SEL (refund_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observation counters, cleared per test section.
    int         pops, valid_cyc, jams, drops, refunds, stab_err;
    int         refund_total = 0;
    int         exp_refund_total = 0;
    logic [1:0] last_refund_sel;
    logic [1:0] popped[$];
    logic [3:0] coin_drv = 4'b0000;
    logic       ready_drv = 1'b1;

    // Scoreboard for the random phase.
    bit         sb_mode = 1'b0;
    logic [1:0] exp_q[$];

    // Previous-sample state for the hold-until-accepted rule.
    bit         have_prev = 1'b0;
    logic       prev_valid, prev_ready;
    logic [1:0] prev_sel;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_stats();
        pops = 0; valid_cyc = 0; jams = 0; drops = 0; refunds = 0; stab_err = 0;
        popped.delete();
    endtask

    task automatic sample();
        if (add_valid) valid_cyc++;
        if (add_valid && add_ready) begin
            pops++;
            popped.push_back(add_sel);
            if (sb_mode) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected_pop: got code %0d expected no coin", add_sel);
                end else begin
                    check("sb_pop_code", add_sel, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (jam)  jams++;
        if (drop) drops++;
        if (refund) begin
            refunds++;
            refund_total++;
            last_refund_sel = refund_sel;
        end
        if (have_prev && prev_valid && !prev_ready && (!add_valid || add_sel != prev_sel))
            stab_err++;
        have_prev  = 1'b1;
        prev_valid = add_valid;
        prev_ready = add_ready;
        prev_sel   = add_sel;
    endtask

    // One clock: drive just after the edge, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        coin      = coin_drv;
        add_ready = ready_drv;
        @(negedge clk);
        sample();
    endtask

    task automatic run_window(input logic [3:0] mask, input int hi, input int total);
        for (int c = 0; c < total; c++) begin
            coin_drv = (c < hi) ? mask : 4'b0000;
            step();
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         hi;
        int         exp_pops;
        logic [1:0] exp_sel;
        int         exp_jam;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // A line qualifies only if it stays high DEB cycles; two at once is a jam.
        vecs[0] = '{4'b0100, 10, 1, 2'b10, 0};
        vecs[1] = '{4'b0001,  2, 0, 2'b00, 0};
        vecs[2] = '{4'b0001,  3, 0, 2'b00, 0};
        vecs[3] = '{4'b0001,  4, 1, 2'b00, 0};
        vecs[4] = '{4'b0010,  6, 1, 2'b01, 0};
        vecs[5] = '{4'b1000, 40, 1, 2'b11, 0};
        vecs[6] = '{4'b1010,  8, 0, 2'b00, 1};
        vecs[7] = '{4'b0101,  8, 0, 2'b00, 1};
        vecs[8] = '{4'b1111,  8, 0, 2'b00, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_add_valid", add_valid, 0);
        check("rst_add_sel", add_sel, 0);
        check("rst_full", full, 0);
        check("rst_drop", drop, 0);
        check("rst_jam", jam, 0);
        check("rst_refund", refund, 0);
        check("rst_refund_sel", refund_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // Table-driven single-event vectors, controller always ready.
        ready_drv = 1'b1;
        for (int v = 0; v < 9; v++) begin
            clear_stats();
            run_window(vecs[v].mask, vecs[v].hi, vecs[v].hi + 20);
            check($sformatf("vec%0d_pops", v), pops, vecs[v].exp_pops);
            check($sformatf("vec%0d_valid_cycles", v), valid_cyc, vecs[v].exp_pops);
            check($sformatf("vec%0d_jam", v), jams, vecs[v].exp_jam);
            check($sformatf("vec%0d_drop", v), drops, 0);
            if (vecs[v].exp_pops > 0)
                check($sformatf("vec%0d_sel", v), popped[0], vecs[v].exp_sel);
        end

        // Fill with the controller stalled, overflow once, then drain.
        clear_stats();
        ready_drv = 1'b0;
        for (int k = 0; k < 4; k++) run_window(4'b0001, 6, 16);
        check("fill_full", full, 1);
        check("fill_valid", add_valid, 1);
        check("fill_sel", add_sel, 0);
        check("fill_no_drop", drops, 0);
        run_window(4'b0001, 6, 16);
        check("overflow_drop", drops, 1);
        check("overflow_full", full, 1);
        check("overflow_stable", stab_err, 0);
        clear_stats();
        ready_drv = 1'b1;
        run_window(4'b0000, 0, 12);
        check("drain_pops", pops, 4);
        check("drain_full", full, 0);
        foreach (popped[i]) check($sformatf("drain_code%0d", i), popped[i], 0);

        // Reset with coins queued and a line mid-debounce that stays high.
        clear_stats();
        ready_drv = 1'b0;
        for (int k = 0; k < 3; k++) run_window(4'b0010, 6, 16);
        check("preq_valid", add_valid, 1);
        check("preq_full", full, 0);
        run_window(4'b1000, 4, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", add_valid, 0);
        check("async_rst_sel", add_sel, 0);
        check("async_rst_full", full, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        have_prev = 1'b0;
        @(negedge clk);
        check("post_rst_valid", add_valid, 0);
        clear_stats();
        run_window(4'b1000, 10, 20);
        check("rehold_valid", add_valid, 1);
        check("rehold_sel", add_sel, 3);
        ready_drv = 1'b1;
        run_window(4'b0000, 0, 10);
        check("rehold_pops", pops, 1);
        check("rehold_empty", add_valid, 0);

`ifdef COIN_REFUND_EN
        // Ceiling: 15 credit + queued 10 + new 2 exceeds 20, so the 2 is refunded.
        clear_stats();
        ready_drv = 1'b0;
        credit = 7'd0;
        run_window(4'b0100, 8, 16);
        check("ref_queued_valid", add_valid, 1);
        credit = 7'd15;
        run_window(4'b0010, 8, 16);
        exp_refund_total = exp_refund_total + 1;
        check("ref_refunds", refunds, 1);
        check("ref_sel", last_refund_sel, 1);
        check("ref_no_drop", drops, 0);
        credit = 7'd0;
        ready_drv = 1'b1;
        clear_stats();
        run_window(4'b0000, 0, 10);
        check("ref_pops", pops, 1);
        check("ref_pop_code", popped[0], 2);
`endif

        // Random events against a rule-level model: long single -> one coin,
        // short -> nothing, simultaneous pair -> jam only.
        begin
            int         kind, l1, l2, hi, gap, jam_exp;
            logic [3:0] m;
            clear_stats();
            exp_q.delete();
            jam_exp = 0;
            sb_mode = 1'b1;
            for (int e = 0; e < 30; e++) begin
                kind = $urandom_range(0, 9);
                l1   = $urandom_range(0, 3);
                l2   = (l1 + $urandom_range(1, 3)) % 4;
                gap  = $urandom_range(14, 20);
                if (kind < 2) begin
                    hi = $urandom_range(1, DEB - 1);
                    m  = 4'b0001 << l1;
                end else if (kind == 2) begin
                    hi = $urandom_range(DEB, 12);
                    m  = (4'b0001 << l1) | (4'b0001 << l2);
                    jam_exp++;
                end else begin
                    hi = $urandom_range(DEB, 20);
                    m  = 4'b0001 << l1;
                    exp_q.push_back(2'(l1));
                end
                for (int c = 0; c < hi + gap; c++) begin
                    coin_drv  = (c < hi) ? m : 4'b0000;
                    ready_drv = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
            ready_drv = 1'b1;
            run_window(4'b0000, 0, 20);
            sb_mode = 1'b0;
            check("rand_leftover", exp_q.size(), 0);
            check("rand_jams", jams, jam_exp);
            check("rand_drops", drops, 0);
            check("rand_stable", stab_err, 0);
        end

        check("refund_total", refund_total, exp_refund_total);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coin_intake.md
COIN_INTAKE -- requirements
Module: coin_intake

Interface
REQ-001 SHALL have parameter DEPTH, default 4, coin FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter DEB_CYC, default 4, cycles a coin line must stay high to qualify.
REQ-003 SHALL have parameter CREDIT_MAX, default 20, credit ceiling in units.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port COIN  in  4  raw coin-mechanism lines, asynchronous; bit0=1, bit1=2, bit2=10, bit3=20 units.
REQ-007 SHALL have port CREDIT  in  7  current credit register value from the datapath.
REQ-008 SHALL have port ADD_READY  in  1  controller can accept one coin this cycle.
REQ-009 SHALL have port ADD_VALID  out  1  head coin available.
REQ-010 SHALL have port ADD_SEL  out  2  head coin code, drives the datapath adder select (00=1, 01=2, 10=10, 11=20).
REQ-011 SHALL have port FULL  out  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port DROP  out  1  one-cycle pulse: qualified coin discarded because FIFO full.
REQ-013 SHALL have port JAM  out  1  one-cycle pulse: more than one line qualified in the same cycle.
REQ-014 SHALL have port REFUND  out  1  one-cycle pulse: coin returned (only with COIN_REFUND_EN).
REQ-015 SHALL have port REFUND_SEL  out  2  code of refunded coin, valid with REFUND.

Function
REQ-016 Each COIN bit SHALL pass a 2-flop synchroniser before any other use.
REQ-017 Each line SHALL run a debounce FSM: IDLE -> COUNT on synced high; COUNT -> IDLE on low before DEB_CYC; COUNT -> HELD after DEB_CYC consecutive high cycles, emitting a one-cycle qualify strobe; HELD -> IDLE on synced low.
REQ-018 One held-high line SHALL produce exactly one coin regardless of duration.
REQ-019 Two or more qualify strobes in the same cycle SHALL assert JAM, push nothing and refund nothing.
REQ-020 A single qualify strobe SHALL push the coin code into the FIFO the following cycle; ADD_VALID SHALL rise one cycle after the push into an empty FIFO.
REQ-021 ADD_VALID/ADD_SEL SHALL stay stable until the cycle ADD_VALID && ADD_READY is high; that cycle pops the head.
REQ-022 Push and pop in the same cycle SHALL both occur; when FULL, the simultaneous pop frees the slot and the push is accepted, no DROP.
REQ-023 Push while FULL without pop SHALL discard the coin and pulse DROP.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 Pending credit SHALL equal CREDIT plus sum of queued coin values, computed in 8 bits, no truncation.

Reset
REQ-026 RST_N low SHALL asynchronously clear synchronisers, debounce FSMs to IDLE, FIFO pointers/occupancy; ADD_VALID, FULL, DROP, JAM, REFUND = 0, ADD_SEL, REFUND_SEL = 00.
REQ-027 Reset asserted mid-debounce or with queued coins SHALL discard them; a line still high at release SHALL re-debounce and qualify once.

Configuration
REQ-028 With COIN_REFUND_EN defined, a coin whose value plus pending credit exceeds CREDIT_MAX SHALL not be pushed; REFUND pulses with REFUND_SEL = its code; refund takes priority over DROP.
REQ-029 Without COIN_REFUND_EN, REFUND and REFUND_SEL SHALL be tied 0 and the ceiling check SHALL be absent; over-limit credit is left to the datapath exceed flag.

Structure
REQ-030 Shared package vm_pkg SHALL hold coin code typedef (2 bits), COIN_VAL constants (1,2,10,20) and the credit width constant 7.
REQ-031 Sub-module coin_debounce (synchroniser plus debounce FSM, one line) SHALL be instantiated four times.

Verification
REQ-032 COIN[2] high 10 cycles, ADD_READY=1, FIFO empty -> one ADD_VALID with ADD_SEL=10, popped in that cycle, single coin.
REQ-033 COIN[0] pulsed high 2 cycles with DEB_CYC=4 -> no push, no ADD_VALID.
REQ-034 ADD_READY=0, five 1-unit coins, DEPTH=4 -> FULL after fourth, DROP on fifth; then ADD_READY=1 -> four pops of code 00.
REQ-035 COIN[1] and COIN[3] rising together -> JAM one cycle, FIFO unchanged.
REQ-036 COIN_REFUND_EN, CREDIT=15, one 10 queued, insert 2 -> REFUND with REFUND_SEL=01, no push.
REQ-037 RST_N low for one cycle with 3 coins queued -> ADD_VALID=0 immediately, occupancy 0 after release.
